spi_frame_ctrl: RTL and testbench
=================================

Name: spi_frame_ctrl

Overview:
- Sequences the byte-level SPI slave. Receives completed bytes and the chip-select line from the slave, and decodes each CS-low frame as one command byte followed by data bytes.
- Drives a simple internal register bus: burst writes and burst reads, with address auto-increment.
- For reads, prefetches register data and loads it into the slave's transmit byte (data_out) before the next SPI byte is shifted.

Parameters:
- AW, 7: register-bus address width; the command byte carries a 7-bit start address.
- IDLE_BYTE, 8'hDD: value driven on tx_data whenever no read data is pending.
- SYNC_STAGES, 2: flip-flop stages used to synchronise CS into the clk domain (minimum 2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  raw SPI chip select from the pad, active low, asynchronous to clk.
- rx_valid  in  1  one-clk pulse from the SPI slave when a byte has completed (already in the clk domain).
- rx_data  in  8  received byte; valid only when rx_valid=1.
- tx_data  out  8  byte for the slave to shift out next; connects to the slave's data_out.
- tx_load  out  1  one-clk pulse when tx_data has just been updated with read data.
- bus_addr  out  AW  register-bus address.
- bus_wdata  out  8  register-bus write data.
- bus_we  out  1  one-clk write strobe.
- bus_re  out  1  one-clk read strobe.
- bus_rdata  in  8  read data; sampled on the clk edge after bus_re.
- busy  out  1  high while a frame is active (synchronised CS is low).
- err_ovr  out  1  sticky overrun flag; cleared on the next CS falling edge.

Behaviour:
- Reset values: tx_data=IDLE_BYTE; tx_load=0; bus_addr=0; bus_wdata=0; bus_we=0; bus_re=0; busy=0; err_ovr=0; state=IDLE; sync chain all 1.
- CS handling:
  - CS passes through SYNC_STAGES flip-flops; edge detection uses the synchronised value.
  - busy follows the inverted synchronised CS.
- States: IDLE, CMD, WR, RD_FETCH, RD_WAIT.
- IDLE: on a synchronised CS falling edge, go to CMD. bus_addr:=0, err_ovr:=0, tx_data:=IDLE_BYTE.
- CMD, on rx_valid:
  - bus_addr := rx_data[AW-1:0].
  - If rx_data[7]=0, go to WR.
  - If rx_data[7]=1, go to RD_FETCH and assert bus_re for exactly the next cycle, with bus_addr already equal to the new address.
- WR, on rx_valid:
  - Same cycle: bus_we=1, bus_wdata=rx_data at the current bus_addr.
  - Following cycle: bus_addr increments by 1, modulo 2^AW (7F wraps to 00).
- RD_FETCH (one cycle, bus_re=1): on the next edge, capture bus_rdata into tx_data, pulse tx_load, go to RD_WAIT.
- Read latency: command byte rx_valid at cycle N, bus_re at N+1, tx_data valid with tx_load=1 at N+2.
- RD_WAIT, on rx_valid (the master's dummy byte):
  - bus_addr := bus_addr+1 (wrapping); go to RD_FETCH.
  - Exactly one bus_re per transmitted byte.
- Overrun: rx_valid in RD_FETCH sets err_ovr=1. The byte is dropped and the sequence continues unaffected.
- Frame end: a synchronised CS rising edge in any state forces IDLE on that edge.
  - tx_data := IDLE_BYTE.
  - Any pending tx_load is suppressed.
  - bus_we and bus_re are not asserted after this edge.
- Simultaneous CS rise and rx_valid: CS wins and the byte is discarded (no bus_we).
- rx_valid while in IDLE: ignored.
- bus_we and bus_re are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values. A frame that is already in progress stays ignored until CS is seen high and then falls again.

Decomposition:
- Package spi_frame_pkg holds:
  - state encoding localparams (IDLE, CMD, WR, RD_FETCH, RD_WAIT);
  - CMD_RD_BIT=7;
  - IDLE_BYTE default.
- One sub-module: sync_edge. It is a SYNC_STAGES-deep synchroniser that outputs the synchronised level plus rise and fall pulses. The CS input passes through it.

Test Plan:
- Write burst: CS low; rx bytes 0x05, 0x11, 0x22 → bus_we at addr 0x05 data 0x11, then addr 0x06 data 0x22; no bus_re; busy=1.
- Read burst: bus_rdata model = addr+0x40. CS low; rx byte 0x83 → bus_re at addr 0x03 one cycle after rx_valid; tx_data=0x43 with tx_load two cycles after it. Dummy byte → tx_data=0x44.
- Wrap: write command 0x7F, two data bytes → writes at addr 0x7F then 0x00.
- Abort: read command 0x90, raise CS on the cycle bus_re is high → no tx_load; tx_data returns to 0xDD; state IDLE; following rx_valid ignored.
- Overrun: inject rx_valid on the RD_FETCH cycle → err_ovr=1 until the next CS fall, then 0.
- Reset: assert rst mid write burst → all outputs at reset values on the same cycle, asynchronously. After release, no writes until a new CS falling edge.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame controller: FSM encoding,
// command-byte layout and the filler byte sent when no read data is pending.
package spi_frame_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_WR       = 3'd2;
    localparam logic [2:0] ST_RD_FETCH = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        CMD      = ST_CMD,
        WR       = ST_WR,
        RD_FETCH = ST_RD_FETCH,
        RD_WAIT  = ST_RD_WAIT
    } state_t;

    localparam int         CMD_RD_BIT        = 7;
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hDD;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Internal register bus driven by the SPI frame controller.
// Strobes are single-cycle and carry no ready: the register file accepts a
// write on any bus_we cycle and presents bus_rdata in time for the edge after bus_re.
interface spi_frame_ctrl_if #(
    parameter int AW = 7
);
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata;
    logic          bus_we;
    logic          bus_re;
    logic [7:0]    bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata
    );
endinterface

// File: rtl/spi_frame_ctrl_sync_edge.sv
// Multi-stage synchroniser with rise/fall pulses. The fall pulse is withheld
// until a genuine high level has crossed the chain, so a line held low through reset is ignored.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic [STAGES-1:0] fill;
    logic              prev;
    logic              armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
            fill  <= '0;
            prev  <= 1'b1;
            armed <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            fill  <= {fill[STAGES-2:0], 1'b1};
            prev  <= level;
            // Once fill is full the chain holds only real samples.
            if (fill[STAGES-1] && level) armed <= 1'b1;
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = prev & ~level & armed;
endmodule

// File: rtl/spi_frame_ctrl.sv
// Decodes CS-low SPI frames (command byte + data bytes) into burst register
// writes and prefetched burst reads with address auto-increment.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int         AW          = 7,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [7:0]            tx_data,
    output logic                  tx_load,
    output logic                  busy,
    output logic                  err_ovr,
    output state_t                state_dbg,
    spi_frame_ctrl_if.master      bus
);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic cs_level, cs_rise, cs_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    state_t        state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_load_q, tx_load_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_q, err_d;
    logic          we_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= IDLE_BYTE;
            tx_load_q <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_load_d = 1'b0;
        addr_d    = addr_q;
        err_d     = err_q;
        we_c      = 1'b0;
        // End of frame overrides everything, including a byte arriving this cycle.
        if (cs_rise) begin
            state_d   = IDLE;
            tx_data_d = IDLE_BYTE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        addr_d    = '0;
                        err_d     = 1'b0;
                        tx_data_d = IDLE_BYTE;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        addr_d  = rx_data[AW-1:0];
                        state_d = rx_data[CMD_RD_BIT] ? RD_FETCH : WR;
                    end
                end
                WR: begin
                    if (rx_valid) begin
                        we_c   = 1'b1;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                RD_FETCH: begin
                    tx_data_d = bus.bus_rdata;
                    tx_load_d = 1'b1;
                    state_d   = RD_WAIT;
                    if (rx_valid) err_d = 1'b1;
                end
                RD_WAIT: begin
                    if (rx_valid) begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = RD_FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.bus_addr  = addr_q;
    assign bus.bus_we    = we_c;
    assign bus.bus_wdata = we_c ? rx_data : 8'h00;
    assign bus.bus_re    = (state_q == RD_FETCH);

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign busy      = ~cs_level;
    assign err_ovr   = err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: bus strobes and tx loads are scored
// against queues filled as each command is issued.
module tb_spi_frame_ctrl;
    import spi_frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;
    logic       err_ovr;
    state_t     state_dbg;

    spi_frame_ctrl_if #(.AW(7)) bus_if ();

    // Register model: each location reads back as its address plus 0x40.
    assign bus_if.bus_rdata = {1'b0, bus_if.bus_addr} + 8'h40;

    spi_frame_ctrl #(.AW(7), .IDLE_BYTE(8'hDD), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .busy      (busy),
        .err_ovr   (err_ovr),
        .state_dbg (state_dbg),
        .bus       (bus_if.master)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];   // {re, we, addr[6:0], wdata}
    logic [7:0]  tx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_wr(input logic [6:0] addr, input logic [7:0] data);
        exp_q.push_back({2'b01, addr, data});
    endtask

    task automatic push_rd(input logic [6:0] addr);
        exp_q.push_back({2'b10, addr, 8'h00});
        tx_q.push_back({1'b0, addr} + 8'h40);
    endtask

    always @(negedge clk) begin
        logic [16:0] got;
        if (!rst) begin
            if (bus_if.bus_we || bus_if.bus_re) begin
                got = {bus_if.bus_re, bus_if.bus_we, bus_if.bus_addr,
                       bus_if.bus_we ? bus_if.bus_wdata : 8'h00};
                if (exp_q.size() == 0) check("unexpected_strobe", {15'h0, got}, 32'h0);
                else                   check("bus_strobe", {15'h0, got}, {15'h0, exp_q.pop_front()});
            end
            if (tx_load) begin
                if (tx_q.size() == 0) check("unexpected_tx_load", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else                  check("tx_load_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        ticks(4);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        ticks(4);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'hDD);
        check({tag, "_tx_load"}, {31'h0, tx_load}, 32'h0);
        check({tag, "_bus_addr"}, {25'h0, bus_if.bus_addr}, 32'h0);
        check({tag, "_bus_wdata"}, {24'h0, bus_if.bus_wdata}, 32'h0);
        check({tag, "_bus_we"}, {31'h0, bus_if.bus_we}, 32'h0);
        check({tag, "_bus_re"}, {31'h0, bus_if.bus_re}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_err_ovr"}, {31'h0, err_ovr}, 32'h0);
        check({tag, "_state"}, {29'h0, state_dbg}, {29'h0, IDLE});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        cs       = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        ticks(2);
        check_reset_values("reset");
        rst = 1'b0;
        ticks(4);

        // Write burst
        frame_start();
        check("wr_busy", {31'h0, busy}, 32'h1);
        check("wr_state_cmd", {29'h0, state_dbg}, {29'h0, CMD});
        push_wr(7'h05, 8'h11);
        push_wr(7'h06, 8'h22);
        send(8'h05);
        send(8'h11);
        send(8'h22);
        ticks(2);
        check("wr_addr_after", {25'h0, bus_if.bus_addr}, 32'h07);
        frame_end();
        check("wr_busy_end", {31'h0, busy}, 32'h0);
        check("wr_state_end", {29'h0, state_dbg}, {29'h0, IDLE});

        // Read burst with latency checks
        frame_start();
        push_rd(7'h03);
        send(8'h83);
        check("rd_re_n1", {31'h0, bus_if.bus_re}, 32'h1);
        check("rd_addr_n1", {25'h0, bus_if.bus_addr}, 32'h03);
        check("rd_load_n1", {31'h0, tx_load}, 32'h0);
        tick();
        check("rd_load_n2", {31'h0, tx_load}, 32'h1);
        check("rd_data_n2", {24'h0, tx_data}, 32'h43);
        check("rd_state_wait", {29'h0, state_dbg}, {29'h0, RD_WAIT});
        ticks(2);
        check("rd_load_pulse", {31'h0, tx_load}, 32'h0);
        check("rd_data_hold", {24'h0, tx_data}, 32'h43);
        push_rd(7'h04);
        send(8'h00);
        check("rd2_re", {31'h0, bus_if.bus_re}, 32'h1);
        check("rd2_addr", {25'h0, bus_if.bus_addr}, 32'h04);
        tick();
        check("rd2_data", {24'h0, tx_data}, 32'h44);
        ticks(2);
        frame_end();
        check("rd_idle_byte", {24'h0, tx_data}, 32'hDD);

        // Address wrap
        frame_start();
        push_wr(7'h7F, 8'hA1);
        push_wr(7'h00, 8'hB2);
        send(8'h7F);
        send(8'hA1);
        send(8'hB2);
        tick();
        frame_end();

        // Abort: synchronised CS rise lands on the bus_re cycle
        frame_start();
        exp_q.push_back({2'b10, 7'h10, 8'h00});
        cs = 1'b1;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h90;
        tick();
        rx_valid = 1'b0;
        check("abort_re", {31'h0, bus_if.bus_re}, 32'h1);
        check("abort_addr", {25'h0, bus_if.bus_addr}, 32'h10);
        check("abort_busy", {31'h0, busy}, 32'h0);
        tick();
        check("abort_no_load", {31'h0, tx_load}, 32'h0);
        check("abort_tx_idle", {24'h0, tx_data}, 32'hDD);
        check("abort_state", {29'h0, state_dbg}, {29'h0, IDLE});
        check("abort_re_off", {31'h0, bus_if.bus_re}, 32'h0);
        send(8'h33);
        tick();
        check("abort_ignored", {29'h0, state_dbg}, {29'h0, IDLE});
        ticks(2);

        // Overrun: byte arrives during RD_FETCH
        frame_start();
        push_rd(7'h20);
        send(8'hA0);
        check("ovr_state_fetch", {29'h0, state_dbg}, {29'h0, RD_FETCH});
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_valid = 1'b0;
        check("ovr_flag", {31'h0, err_ovr}, 32'h1);
        check("ovr_load", {31'h0, tx_load}, 32'h1);
        check("ovr_data", {24'h0, tx_data}, 32'h60);
        check("ovr_state_wait", {29'h0, state_dbg}, {29'h0, RD_WAIT});
        ticks(3);
        check("ovr_sticky", {31'h0, err_ovr}, 32'h1);
        frame_end();
        check("ovr_sticky_cs_high", {31'h0, err_ovr}, 32'h1);
        frame_start();
        check("ovr_cleared", {31'h0, err_ovr}, 32'h0);
        frame_end();

        // Reset mid write burst, CS held low through it
        frame_start();
        push_wr(7'h08, 8'hC3);
        send(8'h08);
        send(8'hC3);
        check("rst_pre_addr", {25'h0, bus_if.bus_addr}, 32'h09);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        rx_valid = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(6);
        check("rst_stale_frame_idle", {29'h0, state_dbg}, {29'h0, IDLE});
        send(8'h09);
        send(8'h12);
        tick();
        check("rst_stale_frame_ignored", {29'h0, state_dbg}, {29'h0, IDLE});
        frame_end();
        frame_start();
        push_wr(7'h0A, 8'h77);
        send(8'h0A);
        send(8'h77);
        tick();
        frame_end();

        // Final report
        check("exp_q_drained", exp_q.size(), 32'h0);
        check("tx_q_drained", tx_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
